// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the fetch-stage PC controller.
// Optional build macro used by the controller: PC_FETCH_MISALIGN_EN.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StFetch = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StDrain = 3'd4
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A single boot cycle still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (clog2(cycles) < 1) ? 1 : clog2(cycles);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} buffer that parks a response while decode is stalled.
// Invalidate takes precedence over load and consume.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic        invalidate_i,
  input  logic [31:0] load_instr_i,
  input  logic [31:0] load_pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else if (invalidate_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= load_instr_i;
      pc_q    <= load_pc_i;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: boot sequencing, single-outstanding imem handshake, EX redirects.
// Define PC_FETCH_MISALIGN_EN to trap misaligned redirect targets to TRAP_VEC.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        stall_f,
  input  logic        stall_d,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        flush_d,
  output logic        flush_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_trap
);

  localparam int unsigned    CntW    = cnt_width(BOOT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(BOOT_CYCLES - 1);

  fetch_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        redir_act;
  logic [31:0] redir_pc;
  logic        redir_trap;

  logic        buf_load;
  logic        buf_consume;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  // Redirects arriving while the core is still booting are ignored.
  assign redir_act = redir_valid && (state_q != StBoot);
  assign imem_addr = pc_in;

`ifdef PC_FETCH_MISALIGN_EN
  assign redir_trap = (redir_target[1:0] != 2'b00);
  assign redir_pc   = redir_trap ? TRAP_VEC : redir_target;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TRAP_VEC, redir_target[1:0]};
  assign redir_trap = 1'b0;
  assign redir_pc   = {redir_target[31:2], 2'b00};
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_f       = 1'b1;
    pc_next       = pc_in + INSTR_BYTES;
    flush_d       = 1'b0;
    flush_e       = 1'b0;
    imem_req      = 1'b0;
    if_valid      = 1'b0;
    if_instr      = 32'h0;
    if_pc         = 32'h0;
    misalign_trap = 1'b0;
    buf_load      = 1'b0;
    buf_consume   = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_next = RESET_VEC;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          stall_f = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        imem_req = !stall_d;
        if (!stall_d && imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          stall_f = 1'b0;
          if (stall_d) begin
            buf_load = 1'b1;
            state_d  = StHold;
          end else begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = pc_in;
            state_d  = StFetch;
          end
        end
      end
      StHold: begin
        if_valid = buf_valid;
        if_instr = buf_instr;
        if_pc    = buf_pc;
        if (!stall_d) begin
          buf_consume = 1'b1;
          state_d     = StFetch;
        end
      end
      StDrain: begin
        if (imem_rvalid) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase

    // Redirect overrides everything decided above for this cycle.
    if (redir_act) begin
      pc_next       = redir_pc;
      stall_f       = 1'b0;
      flush_d       = 1'b1;
      flush_e       = 1'b1;
      if_valid      = 1'b0;
      if_instr      = 32'h0;
      if_pc         = 32'h0;
      misalign_trap = redir_trap;
      buf_load      = 1'b0;
      buf_consume   = 1'b0;
      unique case (state_q)
        StFetch: state_d = (imem_req && imem_gnt) ? StDrain : StFetch;
        StWait:  state_d = imem_rvalid ? StFetch : StDrain;
        StHold:  state_d = StFetch;
        StDrain: state_d = imem_rvalid ? StFetch : StDrain;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk          (clk),
    .reset        (reset),
    .load_i       (buf_load),
    .consume_i    (buf_consume),
    .invalidate_i (redir_act),
    .load_instr_i (imem_rdata),
    .load_pc_i    (pc_in),
    .valid_o      (buf_valid),
    .instr_o      (buf_instr),
    .pc_o         (buf_pc)
  );

endmodule
